// File: rtl/line_follow_controller.sv
// Line-following motion sequencer: debounces the three line sensors and steps a
// steering FSM once per motor period, driving enable/direction to both PWM drivers.
module line_follow_controller #(
    parameter int PERIOD       = 1_000_000,
    parameter int DEBOUNCE     = 16,
    parameter int LOST_PERIODS = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       sensor_l,
    input  logic       sensor_m,
    input  logic       sensor_r,
    output logic       period_start,
    output logic       motor_l_en,
    output logic       motor_l_dir,
    output logic       motor_r_en,
    output logic       motor_r_dir,
    output logic [2:0] state_out
);
    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int LW = $clog2(LOST_PERIODS + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD - 1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE - 1);
    localparam logic [LW-1:0] LOST_LAST = LW'(LOST_PERIODS - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FWD  = 3'd1;
    localparam logic [2:0] S_GL   = 3'd2;
    localparam logic [2:0] S_SL   = 3'd3;
    localparam logic [2:0] S_GR   = 3'd4;
    localparam logic [2:0] S_SR   = 3'd5;
    localparam logic [2:0] S_LOST = 3'd6;
    localparam logic [2:0] S_STOP = 3'd7;

    // motor command packing: {l_en, l_dir, r_en, r_dir}
    localparam logic [3:0] CMD_OFF = 4'b0101;

    logic [CW-1:0] cnt;
    logic          boundary;
    logic [2:0]    raw, cand, filt;
    logic [DW-1:0] dcnt;
    logic [LW-1:0] lost_cnt;
    logic [2:0]    state, next_state;
    logic [3:0]    mot;

    function automatic logic [2:0] map_pat(input logic [2:0] p);
        case (p)
            3'b001:  map_pat = S_GL;
            3'b011:  map_pat = S_SL;
            3'b100:  map_pat = S_GR;
            3'b110:  map_pat = S_SR;
            3'b111:  map_pat = S_LOST;
            default: map_pat = S_FWD;
        endcase
    endfunction

    function automatic logic [3:0] cmd_of(input logic [2:0] s);
        case (s)
            S_FWD:   cmd_of = 4'b1111;
            S_GL:    cmd_of = 4'b0111;
            S_SL:    cmd_of = 4'b1011;
            S_GR:    cmd_of = 4'b1101;
            S_SR:    cmd_of = 4'b1110;
            default: cmd_of = CMD_OFF;
        endcase
    endfunction

    assign boundary = (cnt == CNT_LAST);
    assign raw      = {sensor_l, sensor_m, sensor_r};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            cnt          <= boundary ? '0 : cnt + 1'b1;
            period_start <= boundary;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand <= 3'b111;
            filt <= 3'b111;
            dcnt <= '0;
        end else if (raw != cand) begin
            cand <= raw;
            dcnt <= '0;
        end else if (dcnt == DCNT_LAST) begin
            filt <= cand;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end

    // all-white needs per-state handling; every other pattern maps directly
    always_comb begin
        next_state = map_pat(filt);
        if (filt == 3'b111) begin
            case (state)
                S_LOST:  next_state = (lost_cnt == LOST_LAST) ? S_STOP : S_LOST;
                S_STOP:  next_state = S_STOP;
                default: next_state = S_LOST;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            mot      <= CMD_OFF;
            lost_cnt <= '0;
        end else if (!run) begin
            state <= S_IDLE;
            mot   <= CMD_OFF;
        end else if (boundary) begin
            state <= next_state;
            // LOST keeps whatever the motors were last told
            if (next_state != S_LOST)
                mot <= cmd_of(next_state);
            else
                lost_cnt <= (state == S_LOST) ? lost_cnt + 1'b1 : '0;
        end
    end

    assign {motor_l_en, motor_l_dir, motor_r_en, motor_r_dir} = mot;
    assign state_out = state;
endmodule
